// File: rtl/montre_pkg.sv
// Shared definitions for the system-ID checker: FSM state encodings and
// Avalon-MM word addresses of the sysid slave.
package montre_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/montre_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM once after reset (and
// on each start request), compares them against expected values, flags stalls.
module montre_sysid_checker
  import montre_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'd1698362541,
  parameter int unsigned       TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              id_match,
  output logic              ts_match,
  output logic              timeout_err,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);

  state_t              state, state_nxt;
  logic                auto_start, auto_start_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                avm_address_nxt, avm_read_nxt, busy_nxt, done_nxt;
  logic                id_match_nxt, ts_match_nxt, timeout_err_nxt;
  logic [DATA_W-1:0]   id_value_nxt, ts_value_nxt;

  logic go_c, rd_ok_c, timeout_hit_c;

  assign go_c          = auto_start | start;
  assign rd_ok_c       = avm_read & ~avm_waitrequest;
  // This stall is the one that brings the count up to TIMEOUT_CYCLES.
  assign timeout_hit_c = avm_read & avm_waitrequest &
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      auto_start  <= 1'b1;
      wait_cnt    <= '0;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_nxt;
      auto_start  <= auto_start_nxt;
      wait_cnt    <= wait_cnt_nxt;
      avm_address <= avm_address_nxt;
      avm_read    <= avm_read_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      id_match    <= id_match_nxt;
      ts_match    <= ts_match_nxt;
      timeout_err <= timeout_err_nxt;
      id_value    <= id_value_nxt;
      ts_value    <= ts_value_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (go_c) state_nxt = RD_ID;
      RD_ID: begin
        if (rd_ok_c)            state_nxt = RD_TS;
        else if (timeout_hit_c) state_nxt = DONE;
      end
      RD_TS: if (rd_ok_c || timeout_hit_c) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    auto_start_nxt  = auto_start;
    wait_cnt_nxt    = wait_cnt;
    avm_address_nxt = avm_address;
    avm_read_nxt    = avm_read;
    busy_nxt        = busy;
    done_nxt        = done;
    id_match_nxt    = id_match;
    ts_match_nxt    = ts_match;
    timeout_err_nxt = timeout_err;
    id_value_nxt    = id_value;
    ts_value_nxt    = ts_value;

    case (state)
      IDLE, DONE: begin
        if (go_c) begin
          auto_start_nxt  = 1'b0;
          wait_cnt_nxt    = '0;
          avm_address_nxt = ADDR_ID;
          avm_read_nxt    = 1'b1;
          busy_nxt        = 1'b1;
          done_nxt        = 1'b0;
          id_match_nxt    = 1'b0;
          ts_match_nxt    = 1'b0;
          timeout_err_nxt = 1'b0;
        end
      end
      RD_ID, RD_TS: begin
        if (rd_ok_c) begin
          wait_cnt_nxt = '0;
          if (state == RD_ID) begin
            id_value_nxt    = avm_readdata;
            avm_address_nxt = ADDR_TS;
          end else begin
            ts_value_nxt = avm_readdata;
            avm_read_nxt = 1'b0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            id_match_nxt = (id_value == EXPECTED_ID);
            ts_match_nxt = (avm_readdata == EXPECTED_TS);
          end
        end else if (timeout_hit_c) begin
          avm_read_nxt    = 1'b0;
          busy_nxt        = 1'b0;
          done_nxt        = 1'b1;
          timeout_err_nxt = 1'b1;
        end else if (avm_waitrequest) begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
